// File: rtl/gpr_file.sv
// 32 x 64-bit general-purpose register file: two registered read ports, two write ports.
// Define GPR_BYPASS_EN for same-cycle write-to-read forwarding; the default build returns the old contents.
module gpr_file #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en0,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [0:DATA_W-1] rd_data0,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [0:DATA_W-1] rd_data1,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [0:DATA_W-1] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [0:DATA_W-1] wr_data1
);

    logic [0:DATA_W-1] regs_q [NREGS];
    logic [0:DATA_W-1] regs_d [NREGS];
    logic [0:DATA_W-1] rd_data0_q, rd_data0_d;
    logic [0:DATA_W-1] rd_data1_q, rd_data1_d;

    // Port 1 is applied last so it wins when both ports name the same register.
    always_comb begin
        regs_d = regs_q;
        if (wr_en0) begin
            regs_d[wr_addr0] = wr_data0;
        end
        if (wr_en1) begin
            regs_d[wr_addr1] = wr_data1;
        end
    end

`ifdef GPR_BYPASS_EN
    always_comb begin
        rd_data0_d = rd_data0_q;
        if (rd_en0) begin
            if (wr_en1 && (wr_addr1 == rd_addr0)) begin
                rd_data0_d = wr_data1;
            end else if (wr_en0 && (wr_addr0 == rd_addr0)) begin
                rd_data0_d = wr_data0;
            end else begin
                rd_data0_d = regs_q[rd_addr0];
            end
        end
    end

    always_comb begin
        rd_data1_d = rd_data1_q;
        if (rd_en1) begin
            if (wr_en1 && (wr_addr1 == rd_addr1)) begin
                rd_data1_d = wr_data1;
            end else if (wr_en0 && (wr_addr0 == rd_addr1)) begin
                rd_data1_d = wr_data0;
            end else begin
                rd_data1_d = regs_q[rd_addr1];
            end
        end
    end
`else
    // Reads sample the array before this edge's writes land, so they see old contents.
    always_comb begin
        rd_data0_d = rd_data0_q;
        if (rd_en0) begin
            rd_data0_d = regs_q[rd_addr0];
        end
    end

    always_comb begin
        rd_data1_d = rd_data1_q;
        if (rd_en1) begin
            rd_data1_d = regs_q[rd_addr1];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data0_q <= '0;
            rd_data1_q <= '0;
        end else begin
            regs_q     <= regs_d;
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
        end
    end

    assign rd_data0 = rd_data0_q;
    assign rd_data1 = rd_data1_q;

endmodule

// File: tb/tb_gpr_file.sv
// Directed self-checking bench for gpr_file; expected values are hand-computed constants.
// Same-cycle read/write expectations follow GPR_BYPASS_EN exactly as the design build does.
module tb_gpr_file;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              clk;
    logic              rst_n;
    logic              rd_en0;
    logic [ADDR_W-1:0] rd_addr0;
    logic [0:DATA_W-1] rd_data0;
    logic              rd_en1;
    logic [ADDR_W-1:0] rd_addr1;
    logic [0:DATA_W-1] rd_data1;
    logic              wr_en0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [0:DATA_W-1] wr_data0;
    logic              wr_en1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [0:DATA_W-1] wr_data1;

    int vectorsApplied = 0;
    int miscompares    = 0;

    gpr_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREGS (NREGS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en0  (rd_en0),
        .rd_addr0(rd_addr0),
        .rd_data0(rd_data0),
        .rd_en1  (rd_en1),
        .rd_addr1(rd_addr1),
        .rd_data1(rd_data1),
        .wr_en0  (wr_en0),
        .wr_addr0(wr_addr0),
        .wr_data0(wr_data0),
        .wr_en1  (wr_en1),
        .wr_addr1(wr_addr1),
        .wr_data1(wr_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it before checking or driving.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        rd_en0 = 1'b0; rd_addr0 = '0;
        rd_en1 = 1'b0; rd_addr1 = '0;
        wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
        wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [0:DATA_W-1] observed,
                               input logic [0:DATA_W-1] expected);
        vectorsApplied++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [0:DATA_W-1] rdwExpect;
        logic [0:DATA_W-1] dualRdwExpect;
`ifdef GPR_BYPASS_EN
        rdwExpect     = 64'h2;
        dualRdwExpect = 64'h44;
`else
        rdwExpect     = 64'h1;
        dualRdwExpect = 64'h0;
`endif
        idleInputs();
        rst_n = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_rd0", rd_data0, 64'h0);
        checkOutput("reset_rd1", rd_data1, 64'h0);
        rst_n = 1'b1;
        applyStimulus();

        // Write r5 then read it one cycle later.
        wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 64'h0123456789ABCDEF;
        applyStimulus();
        idleInputs();
        rd_en0 = 1'b1; rd_addr0 = 5'd5;
        applyStimulus();
        checkOutput("read_r5", rd_data0, 64'h0123456789ABCDEF);
        checkOutput("rd1_untouched", rd_data1, 64'h0);

        // Disabled read holds while r5 is overwritten with zero.
        idleInputs();
        wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 64'h0;
        applyStimulus();
        checkOutput("hold_1", rd_data0, 64'h0123456789ABCDEF);
        idleInputs();
        applyStimulus();
        checkOutput("hold_2", rd_data0, 64'h0123456789ABCDEF);
        rd_en0 = 1'b1; rd_addr0 = 5'd5;
        applyStimulus();
        checkOutput("reread_r5", rd_data0, 64'h0);

        // Dual write to different indices, then colliding indices.
        idleInputs();
        wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 64'h11;
        wr_en1 = 1'b1; wr_addr1 = 5'd4; wr_data1 = 64'h22;
        applyStimulus();
        idleInputs();
        rd_en0 = 1'b1; rd_addr0 = 5'd3;
        rd_en1 = 1'b1; rd_addr1 = 5'd4;
        applyStimulus();
        checkOutput("dual_r3", rd_data0, 64'h11);
        checkOutput("dual_r4", rd_data1, 64'h22);
        idleInputs();
        wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 64'hAA;
        wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 64'hBB;
        applyStimulus();
        idleInputs();
        rd_en0 = 1'b1; rd_addr0 = 5'd7;
        rd_en1 = 1'b1; rd_addr1 = 5'd7;
        applyStimulus();
        checkOutput("collide_r7_p0", rd_data0, 64'hBB);
        checkOutput("collide_r7_p1", rd_data1, 64'hBB);

        // Read-during-write on r9 from both read ports.
        idleInputs();
        wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 64'h1;
        applyStimulus();
        wr_data0 = 64'h2;
        rd_en0 = 1'b1; rd_addr0 = 5'd9;
        rd_en1 = 1'b1; rd_addr1 = 5'd9;
        applyStimulus();
        checkOutput("rdw_r9_p0", rd_data0, rdwExpect);
        checkOutput("rdw_r9_p1", rd_data1, rdwExpect);
        idleInputs();
        rd_en0 = 1'b1; rd_addr0 = 5'd9;
        applyStimulus();
        checkOutput("after_rdw_r9", rd_data0, 64'h2);

        // Read-during-write with both write ports on r10: port 1 data is the one forwarded.
        idleInputs();
        wr_en0 = 1'b1; wr_addr0 = 5'd10; wr_data0 = 64'h33;
        wr_en1 = 1'b1; wr_addr1 = 5'd10; wr_data1 = 64'h44;
        rd_en1 = 1'b1; rd_addr1 = 5'd10;
        applyStimulus();
        checkOutput("rdw_dual_r10", rd_data1, dualRdwExpect);
        idleInputs();
        rd_en1 = 1'b1; rd_addr1 = 5'd10;
        applyStimulus();
        checkOutput("after_dual_r10", rd_data1, 64'h44);

        // r0 is an ordinary register.
        idleInputs();
        wr_en1 = 1'b1; wr_addr1 = 5'd0; wr_data1 = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus();
        idleInputs();
        rd_en0 = 1'b1; rd_addr0 = 5'd0;
        rd_en1 = 1'b1; rd_addr1 = 5'd31;
        applyStimulus();
        checkOutput("r0_ones", rd_data0, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("r31_zero", rd_data1, 64'h0);

        // Asynchronous reset mid-run with a write attempted while held.
        idleInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rd0", rd_data0, 64'h0);
        checkOutput("async_rst_rd1", rd_data1, 64'h0);
        wr_en0 = 1'b1; wr_addr0 = 5'd12; wr_data0 = 64'hDEAD;
        rd_en0 = 1'b1; rd_addr0 = 5'd0;
        applyStimulus();
        checkOutput("held_rst_rd0", rd_data0, 64'h0);
        idleInputs();
        rst_n = 1'b1;
        rd_en0 = 1'b1; rd_addr0 = 5'd0;
        rd_en1 = 1'b1; rd_addr1 = 5'd7;
        applyStimulus();
        checkOutput("post_rst_r0", rd_data0, 64'h0);
        checkOutput("post_rst_r7", rd_data1, 64'h0);
        rd_addr0 = 5'd12;
        rd_addr1 = 5'd10;
        applyStimulus();
        checkOutput("post_rst_r12", rd_data0, 64'h0);
        checkOutput("post_rst_r10", rd_data1, 64'h0);
        rd_addr0 = 5'd5;
        rd_addr1 = 5'd9;
        applyStimulus();
        checkOutput("post_rst_r5", rd_data0, 64'h0);
        checkOutput("post_rst_r9", rd_data1, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
